// File: rtl/branch_resolve_bht.sv
// EX-stage branch resolution with a 2-bit saturating-counter BHT for fetch prediction.
// Outcome, mispredict/flush and illegal-funct3 flags are registered; perf counters saturate.
module branch_resolve_bht #(
  parameter int         XLEN        = 64,
  parameter int         BHT_ENTRIES = 16,
  parameter logic [1:0] INIT_STATE  = 2'b01
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [XLEN-1:0] if_pc,
  output logic            pred_taken,
  input  logic            ex_valid,
  input  logic            ex_branch,
  input  logic [2:0]      ex_funct3,
  input  logic [XLEN-1:0] ex_rs1,
  input  logic [XLEN-1:0] ex_rs2,
  input  logic [XLEN-1:0] ex_pc,
  input  logic            ex_pred_taken,
  input  logic            stat_clr,
  output logic            res_valid,
  output logic            res_taken,
  output logic            mispredict,
  output logic            flush,
  output logic            illegal_funct3,
  output logic [31:0]     branch_count,
  output logic [31:0]     mispredict_count
);

  localparam int IDX = $clog2(BHT_ENTRIES);

  logic [1:0]             bht_reg [BHT_ENTRIES];
  logic [BHT_ENTRIES-1:0] bht_we;
  logic [IDX-1:0]         if_idx;
  logic [IDX-1:0]         ex_idx;
  logic [1:0]             ctr_cur;
  logic [1:0]             ctr_next;

  logic rs_eq, rs_lt, rs_ltu;
  logic legal, cond_taken;
  logic resolve, legal_resolve, mispredict_next;

  logic        res_valid_reg, res_taken_reg, mispredict_reg, flush_reg, illegal_reg;
  logic [31:0] branch_count_reg, branch_count_next;
  logic [31:0] mispredict_count_reg, mispredict_count_next;

  // pc[1:0] is always zero for aligned instructions, so the index starts at bit 2
  assign if_idx     = if_pc[IDX+1:2];
  assign ex_idx     = ex_pc[IDX+1:2];
  assign pred_taken = bht_reg[if_idx][1];

  assign rs_eq  = (ex_rs1 == ex_rs2);
  assign rs_lt  = ($signed(ex_rs1) < $signed(ex_rs2));
  assign rs_ltu = (ex_rs1 < ex_rs2);

  always_comb begin
    legal      = 1'b1;
    cond_taken = 1'b0;
    case (ex_funct3)
      3'b000:  cond_taken = rs_eq;
      3'b001:  cond_taken = ~rs_eq;
      3'b100:  cond_taken = rs_lt;
      3'b101:  cond_taken = ~rs_lt;
      3'b110:  cond_taken = rs_ltu;
      3'b111:  cond_taken = ~rs_ltu;
      default: legal      = 1'b0;
    endcase
  end

  assign resolve         = ex_valid & ex_branch;
  assign legal_resolve   = resolve & legal;
  assign mispredict_next = legal_resolve & (cond_taken ^ ex_pred_taken);

  assign ctr_cur = bht_reg[ex_idx];

  always_comb begin
    ctr_next = ctr_cur;
    if (cond_taken) begin
      if (ctr_cur != 2'b11) ctr_next = ctr_cur + 2'd1;
    end else begin
      if (ctr_cur != 2'b00) ctr_next = ctr_cur - 2'd1;
    end
  end

  generate
    for (genvar gi = 0; gi < BHT_ENTRIES; gi++) begin : g_bht_we
      assign bht_we[gi] = legal_resolve && (ex_idx == IDX'(gi));
    end
  endgenerate

  // Prediction reads the array before this edge's write lands, giving old-value-on-collision
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BHT_ENTRIES; i++) bht_reg[i] <= INIT_STATE;
    end else begin
      for (int i = 0; i < BHT_ENTRIES; i++) begin
        if (bht_we[i]) bht_reg[i] <= ctr_next;
      end
    end
  end

  always_comb begin
    branch_count_next     = branch_count_reg;
    mispredict_count_next = mispredict_count_reg;
    if (stat_clr) begin
      branch_count_next     = '0;
      mispredict_count_next = '0;
    end else begin
      if (legal_resolve && (branch_count_reg != 32'hFFFF_FFFF))
        branch_count_next = branch_count_reg + 32'd1;
      if (mispredict_next && (mispredict_count_reg != 32'hFFFF_FFFF))
        mispredict_count_next = mispredict_count_reg + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_valid_reg        <= 1'b0;
      res_taken_reg        <= 1'b0;
      mispredict_reg       <= 1'b0;
      flush_reg            <= 1'b0;
      illegal_reg          <= 1'b0;
      branch_count_reg     <= '0;
      mispredict_count_reg <= '0;
    end else begin
      res_valid_reg        <= resolve;
      res_taken_reg        <= legal_resolve & cond_taken;
      mispredict_reg       <= mispredict_next;
      flush_reg            <= mispredict_next;
      illegal_reg          <= resolve & ~legal;
      branch_count_reg     <= branch_count_next;
      mispredict_count_reg <= mispredict_count_next;
    end
  end

  assign res_valid        = res_valid_reg;
  assign res_taken        = res_taken_reg;
  assign mispredict       = mispredict_reg;
  assign flush            = flush_reg;
  assign illegal_funct3   = illegal_reg;
  assign branch_count     = branch_count_reg;
  assign mispredict_count = mispredict_count_reg;

endmodule

// File: doc/branch_resolve_bht.md
# branch_resolve_bht

Parametrised branch resolution unit for the EX stage of the RISC-V pipeline, with a built-in branch history table (BHT) for fetch-stage prediction. It evaluates all six RV64 conditional-branch conditions (signed and unsigned) and registers the outcome into the EX/MEM boundary. It compares the outcome against the prediction made at fetch, raises a one-cycle flush on mispredict, and trains a table of 2-bit saturating counters. Saturating branch and mispredict counters are kept for performance debug.

## Interface
- XLEN, 64: operand and PC width.
- BHT_ENTRIES, 16: number of 2-bit counters; power of two, minimum 2. IDX = log2(BHT_ENTRIES).
- INIT_STATE, 2'b01: counter value loaded on reset (weakly not-taken).
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- if_pc  in  XLEN  fetch PC to predict.
- pred_taken  out  1  combinational prediction for if_pc.
- ex_valid  in  1  EX stage holds a valid instruction.
- ex_branch  in  1  EX instruction is a conditional branch.
- ex_funct3  in  3  branch type.
- ex_rs1, ex_rs2  in  XLEN  forwarded operands.
- ex_pc  in  XLEN  PC of the EX branch.
- ex_pred_taken  in  1  prediction carried down the pipe from fetch.
- stat_clr  in  1  synchronous clear of the statistics counters.
- res_valid  out  1  registered: a branch was resolved last cycle.
- res_taken  out  1  registered branch outcome.
- mispredict  out  1  registered: res_taken != ex_pred_taken.
- flush  out  1  registered one-cycle pulse, equal to mispredict.
- illegal_funct3  out  1  registered: branch with funct3 010 or 011.
- branch_count  out  32  legal branches resolved, saturating.
- mispredict_count  out  32  mispredicts, saturating.

## Operation
- BHT index is pc[IDX+1:2]. Instructions are word-aligned, so pc[1:0] is ignored.
- Prediction: pred_taken = BHT[if_pc index][1].
- Conditions are evaluated when ex_valid & ex_branch:
  - 000 beq: rs1 == rs2
  - 001 bne: rs1 != rs2
  - 100 blt: signed rs1 < rs2
  - 101 bge: signed rs1 >= rs2
  - 110 bltu: unsigned rs1 < rs2
  - 111 bgeu: unsigned rs1 >= rs2
- Comparisons use the full XLEN width with no truncation.
- Counter training on a legal resolve:
  - taken: state + 1, saturating at 11.
  - not taken: state - 1, saturating at 00.
  - States: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T.
- Illegal funct3 (010/011):
  - res_valid=1, res_taken=0, illegal_funct3=1, mispredict=0, flush=0.
  - No BHT update and no counter increment.
- No resolve (ex_valid=0 or ex_branch=0): res_valid, res_taken, mispredict, flush and illegal_funct3 are all 0 on the next cycle.
- Statistics:
  - branch_count increments on every legal resolve.
  - mispredict_count increments on every mispredict.
  - Both hold at 32'hFFFF_FFFF once saturated.
  - stat_clr has priority and zeroes both. An event in the same cycle as stat_clr is not counted.

## Timing
- Reset (rst_n=0), asynchronous: all registered outputs go to 0, both counters to 0, every BHT entry to INIT_STATE. Reset mid-operation discards any in-flight resolve.
- Resolve latency is 1 cycle: the inputs sampled at edge N appear on the res_* / flush outputs after edge N and are valid for exactly one cycle.
- The BHT write happens at the same edge N.
- pred_taken is combinational from the current array contents.
- Same cycle, same index (if_pc and ex_pc map to the same entry): pred_taken returns the pre-update value. The trained value is visible from cycle N+1.
- Back-to-back resolves on consecutive cycles are each trained and counted. The same entry on consecutive cycles accumulates: 01 -> 10 -> 11.
- flush is never asserted for two consecutive cycles unless two consecutive resolves both mispredict.

## Test plan
- Reset then no stimulus:
  - all outputs are 0.
  - pred_taken=0 for any if_pc (INIT 01).
  - Deassert rst_n mid-resolve -> outputs clear immediately.
- Compare coverage, each funct3 with rs1=64'hFFFF_FFFF_FFFF_FFFF, rs2=1:
  - blt taken, bltu not taken, bge not taken, bgeu taken.
  - beq/bne with equal operands give 1/0.
- Mispredict path:
  - ex_pc=0x40, ex_pred_taken=0, beq with equal operands -> next cycle res_taken=1, mispredict=1, flush=1 for one cycle.
  - BHT[0] goes 01->10, so pred_taken for if_pc=0x40 is 1.
- Saturation: 4 taken resolves on pc 0x8 -> counter 11. Then 1 not-taken -> 10, prediction still taken. Then 2 not-taken -> 00.
- Illegal funct3=010 -> illegal_funct3=1, res_taken=0, no BHT change, branch_count unchanged.
- Statistics:
  - Force branch_count to 32'hFFFF_FFFF, then resolve -> stays at 32'hFFFF_FFFF.
  - stat_clr together with a mispredict -> both counters read 0.
